p2s: RTL and testbench

- Output stage directly downstream of the encryption/decryption pipeline.
- Buffers 128-bit result blocks in an internal FIFO and serializes each block into OUT_W-bit beats for the downstream interface.
- Drives the FIFO occupancy flags fifo_almost_full and fifo_full. The control block uses these to raise hold toward the upstream sender and to stall s2p/encdec/p2s.

---
 rtl/p2s_if.sv | 24 ++
 rtl/p2s.sv | 142 ++++++++++++++
 tb/tb_p2s.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/p2s_if.sv
// p2s_if: data-path bundle for the p2s output stage.
// The slave modport is the p2s view: blocks and back-pressure come in,
// serialized beats go out. The master modport is the surrounding logic.
interface p2s_if #(
  parameter int DATA_W = 128,
  parameter int OUT_W  = 32
) ();
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic [OUT_W-1:0]  dout;
  logic              dout_valid;
  logic              dout_last;
  logic              hold_o;

  modport slave (
    input  din, din_valid, hold_o,
    output dout, dout_valid, dout_last
  );

  modport master (
    output din, din_valid, hold_o,
    input  dout, dout_valid, dout_last
  );
endinterface

// File: rtl/p2s.sv
// p2s: buffers DATA_W-bit result blocks in a DEPTH-entry FIFO and serializes
// each block into OUT_W-bit beats, most-significant word first.
// Optional macro P2S_OVERFLOW_FLAG_EN: when defined, overflow becomes a
// sticky write-while-full indicator; otherwise it is tied low.
module p2s #(
  parameter int DATA_W    = 128,
  parameter int OUT_W     = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  p2s_if.slave                   bus,
  output logic                   fifo_almost_full,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);
  localparam int BEATS = DATA_W / OUT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              wr_en, pop, xfer, last_beat;

  // Full blocks writes even when a pop happens in the same cycle.
  assign wr_en            = bus.din_valid && !fifo_full;
  assign fifo_full        = (count_q == CW'(DEPTH));
  assign fifo_almost_full = (count_q >= CW'(AF_THRESH));
  assign fifo_count       = count_q;

  assign last_beat      = (beat_cnt_q == BW'(BEATS - 1));
  assign bus.dout       = shreg_q[DATA_W-1 -: OUT_W];
  assign bus.dout_valid = (state_q == SEND);
  assign bus.dout_last  = (state_q == SEND) && last_beat;
  assign xfer           = bus.dout_valid && !bus.hold_o;

  // FIFO storage write; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Occupancy next value: simultaneous write and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Serializer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Serializer next state: load a block, shift out beats, chain blocks
  // back-to-back when the FIFO still holds data after the last beat.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    beat_cnt_d = beat_cnt_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          shreg_d    = mem_q[rd_ptr_q];
          beat_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (!last_beat) begin
            shreg_d    = shreg_q << OUT_W;
            beat_cnt_d = beat_cnt_q + BW'(1);
          end else if (count_q != '0) begin
            pop        = 1'b1;
            shreg_d    = mem_q[rd_ptr_q];
            beat_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef P2S_OVERFLOW_FLAG_EN
  logic overflow_q;

  // Sticky write-while-full flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else if (bus.din_valid && fifo_full) overflow_q <= 1'b1;
  end

  // Simulation-only notice of a dropped block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.din_valid && fifo_full))
        else $error("p2s: block dropped, write while FIFO full");
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_p2s.sv
// tb_p2s: directed scenarios plus a randomized phase, checked against a
// beat-queue scoreboard and an occupancy model derived from block counts.
module tb_p2s;
  localparam int DATA_W    = 128;
  localparam int OUT_W     = 32;
  localparam int DEPTH     = 8;
  localparam int AF_THRESH = 6;
  localparam int BEATS     = DATA_W / OUT_W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_almost_full, fifo_full, overflow;
  logic [3:0] fifo_count;

  p2s_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  p2s #(.DATA_W(DATA_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.slave),
    .fifo_almost_full (fifo_almost_full),
    .fifo_full        (fifo_full),
    .fifo_count       (fifo_count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expq[$];
  int          written = 0;
  int          consumed = 0;
  int          mcount = 0;
  int          peak = 0;
  bit          ovf_model = 1'b0;
  bit          ovf_exp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: update the model at the edge, check at the falling edge.
  task automatic tick();
    logic        wr, ovf_ev, xf, pv, ph, pl;
    logic [31:0] pd;
    logic [127:0] tmp;
    int          started;
    wr     = bus.din_valid && (mcount < DEPTH);
    ovf_ev = bus.din_valid && (mcount == DEPTH);
    xf     = bus.dout_valid && !bus.hold_o;
    pv = bus.dout_valid; ph = bus.hold_o; pl = bus.dout_last; pd = bus.dout;
    tmp = bus.din;
    @(posedge clk);
    if (wr) begin
      for (int b = 0; b < BEATS; b++) begin
        expq.push_back(tmp[127:96]);
        tmp = tmp << 32;
      end
      written++;
    end
    if (ovf_ev) ovf_model = 1'b1;
    if (xf) begin
      chk("beat_expected", 128'(expq.size() != 0), 128'(1));
      if (expq.size() != 0) begin
        chk("beat_data", 128'(pd), 128'(expq[0]));
        chk("beat_last", 128'(pl), 128'((consumed % BEATS) == BEATS - 1));
        void'(expq.pop_front());
        consumed++;
      end
    end
    @(negedge clk);
    started = consumed / BEATS + (bus.dout_valid ? 1 : 0);
    mcount  = written - started;
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
`ifdef P2S_OVERFLOW_FLAG_EN
    ovf_exp = ovf_model;
`else
    ovf_exp = 1'b0;
`endif
    chk("fifo_count", 128'(fifo_count), 128'(mcount));
    chk("fifo_full", 128'(fifo_full), 128'(mcount == DEPTH));
    chk("fifo_almost_full", 128'(fifo_almost_full), 128'(mcount >= AF_THRESH));
    chk("overflow", 128'(overflow), 128'(ovf_exp));
    if (pv && ph)
      chk("hold_stable", 128'({bus.dout_valid, bus.dout_last, bus.dout}), 128'({1'b1, pl, pd}));
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (expq.size() != 0 || bus.dout_valid); n++) tick();
    chk("drain_empty", 128'(expq.size()), 128'(0));
    chk("drain_idle", 128'(bus.dout_valid), 128'(0));
  endtask

  task automatic put_block(input logic [127:0] d);
    bus.din = d; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  logic [31:0]  cw [4];
  logic [127:0] c128;

  initial begin
    cw[0] = 32'h01234567; cw[1] = 32'h89abcdef; cw[2] = 32'hfedcba98; cw[3] = 32'h76543210;
    c128 = 128'h0123456789abcdeffedcba9876543210;
    bus.din = '0; bus.din_valid = 1'b0; bus.hold_o = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    // Reset state
    chk("rst_dout", 128'(bus.dout), 128'(0));
    chk("rst_valid", 128'(bus.dout_valid), 128'(0));
    chk("rst_last", 128'(bus.dout_last), 128'(0));
    chk("rst_count", 128'(fifo_count), 128'(0));
    chk("rst_full", 128'(fifo_full), 128'(0));
    chk("rst_af", 128'(fifo_almost_full), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    $display("step reset: done");

    // Single block, latency and beat order
    put_block(c128);
    chk("lat_not_yet", 128'(bus.dout_valid), 128'(0));
    for (int k = 0; k < BEATS; k++) begin
      tick();
      chk("single_valid", 128'(bus.dout_valid), 128'(1));
      chk("single_word", 128'(bus.dout), 128'(cw[k]));
      chk("single_last", 128'(bus.dout_last), 128'(k == BEATS - 1));
    end
    tick();
    chk("single_end", 128'(bus.dout_valid), 128'(0));
    $display("step single block: done");

    // Back-to-back blocks: no bubbles, last on every 4th beat
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      bus.din = rnd128(); bus.din_valid = 1'b1;
      tick();
    end
    bus.din_valid = 1'b0;
    for (int k = 0; k < 3 * BEATS - 1; k++) begin
      chk("b2b_valid", 128'(bus.dout_valid), 128'(1));
      chk("b2b_last", 128'(bus.dout_last), 128'((consumed % BEATS) == BEATS - 1));
      tick();
    end
    chk("b2b_done", 128'(bus.dout_valid), 128'(0));
    chk("b2b_peak", 128'(peak), 128'(2));
    drain();
    $display("step back-to-back: done");

    // Back-pressure on beat 2
    put_block(rnd128());
    tick(); tick();
    bus.hold_o = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_word", 128'(bus.dout), 128'(expq[0]));
    end
    bus.hold_o = 1'b0;
    drain();
    $display("step back-pressure: done");

    // Fill while the serializer is held, then overflow and drain
    put_block(rnd128());
    tick();
    bus.hold_o = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      bus.din = rnd128(); bus.din_valid = 1'b1;
      tick();
      if (i == 5) chk("fill_af5", 128'(fifo_almost_full), 128'(0));
      if (i == 6) chk("fill_af6", 128'(fifo_almost_full), 128'(1));
      if (i == 8) chk("fill_full8", 128'(fifo_full), 128'(1));
      if (i >= 8) chk("fill_count", 128'(fifo_count), 128'(8));
    end
    bus.din_valid = 1'b0;
    bus.hold_o = 1'b0;
    drain();
    $display("step fill/overflow: done");

    // Simultaneous write and pop at count 3
    put_block(rnd128());
    tick();
    bus.hold_o = 1'b1;
    for (int i = 0; i < 3; i++) put_block(rnd128());
    chk("sim_pre_count", 128'(fifo_count), 128'(3));
    bus.hold_o = 1'b0;
    for (int n = 0; n < 10 && !bus.dout_last; n++) tick();
    chk("sim_found_last", 128'(bus.dout_last), 128'(1));
    put_block(rnd128());
    chk("sim_count", 128'(fifo_count), 128'(3));
    drain();
    $display("step simultaneous write/pop: done");

    // Reset in the middle of a block
    put_block(rnd128());
    tick(); tick();
    chk("mid_valid", 128'(bus.dout_valid), 128'(1));
    #2 rst = 1'b1;
    #1;
    chk("mrst_dout", 128'(bus.dout), 128'(0));
    chk("mrst_valid", 128'(bus.dout_valid), 128'(0));
    chk("mrst_last", 128'(bus.dout_last), 128'(0));
    chk("mrst_count", 128'(fifo_count), 128'(0));
    expq.delete(); written = 0; consumed = 0; mcount = 0; ovf_model = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_idle", 128'(bus.dout_valid), 128'(0));
    end
    $display("step mid-block reset: done");

    // Randomized traffic; the sender honours the almost-full hold
    for (int n = 0; n < 400; n++) begin
      bus.din       = rnd128();
      bus.din_valid = !fifo_almost_full && ($urandom_range(2) != 0);
      bus.hold_o    = ($urandom_range(3) == 0);
      tick();
    end
    bus.din_valid = 1'b0;
    bus.hold_o    = 1'b0;
    drain();
    $display("step random: %0d blocks written", written);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
